// File: rtl/stencil_test_sequencer.sv
// stencil_test_sequencer
//   Initiator side of the stencil buffer test interface. Accepts one rasterised
//   fragment at a time, snapshots it together with the programmed stencil state,
//   runs a single start/done transaction against the stencil buffer (aborting
//   after TIMEOUT_CYCLES), then forwards the fragment tagged pass/fail/timeout.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cfg_*_i                stencil configuration write port and flush pulse
//   frag_*                 upstream fragment valid/ready stream
//   sb_*                   stencil buffer transaction (start held until done)
//   out_*                  downstream tagged-fragment valid/ready stream
//   busy_o                 transaction in flight (not IDLE)
//   pass_cnt_o/fail_cnt_o  wrapping counts of emitted pass / non-pass results
module stencil_test_sequencer #(
    parameter  int unsigned X_RES          = 1280,
    parameter  int unsigned Y_RES          = 720,
    parameter  int unsigned STENCIL_SIZE   = 8,
    parameter  int unsigned TIMEOUT_CYCLES = 15,
    localparam int unsigned XW             = $clog2(X_RES),
    localparam int unsigned YW             = $clog2(Y_RES)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cfg_we_i,
    input  logic [2:0]              cfg_func_i,
    input  logic [STENCIL_SIZE-1:0] cfg_ref_i,
    input  logic [2:0]              cfg_sfail_i,
    input  logic [2:0]              cfg_dpfail_i,
    input  logic [2:0]              cfg_dppass_i,
    input  logic                    cfg_flush_i,
    input  logic                    frag_valid_i,
    output logic                    frag_ready_o,
    input  logic [XW-1:0]           frag_x_i,
    input  logic [YW-1:0]           frag_y_i,
    input  logic                    frag_depth_pass_i,
    output logic                    sb_start_o,
    output logic [XW-1:0]           sb_pixel_x_o,
    output logic [YW-1:0]           sb_pixel_y_o,
    output logic [STENCIL_SIZE-1:0] sb_frag_stencil_o,
    output logic [2:0]              sb_stencil_func_o,
    output logic [2:0]              sb_sfail_o,
    output logic [2:0]              sb_dpfail_o,
    output logic [2:0]              sb_dppass_o,
    output logic                    sb_depth_pass_o,
    output logic                    sb_flush_o,
    input  logic                    sb_stencil_pass_i,
    input  logic                    sb_done_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [XW-1:0]           out_x_o,
    output logic [YW-1:0]           out_y_o,
    output logic                    out_pass_o,
    output logic                    out_timeout_o,
    output logic                    busy_o,
    output logic [15:0]             pass_cnt_o,
    output logic [15:0]             fail_cnt_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EMIT} state_e;

    state_e state_q, state_d;

    logic [2:0]              cfg_func_q, cfg_sfail_q, cfg_dpfail_q, cfg_dppass_q;
    logic [STENCIL_SIZE-1:0] cfg_ref_q;
    logic                    flush_pend_q;

    logic [XW-1:0]           snap_x_q;
    logic [YW-1:0]           snap_y_q;
    logic                    snap_dp_q;
    logic [2:0]              snap_func_q, snap_sfail_q, snap_dpfail_q, snap_dppass_q;
    logic [STENCIL_SIZE-1:0] snap_ref_q;
    logic                    snap_flush_q;

    logic [TW-1:0]           tmo_cnt_q;
    logic                    pass_cap_q;
    logic                    out_pass_q, out_timeout_q;
    logic [15:0]             pass_cnt_q, fail_cnt_q;

    logic accept, tmo_hit, first_issue, issue_end, emit_hs;

    assign accept      = (state_q == S_IDLE) && frag_valid_i;
    // The counter holds the number of ISSUE cycles already completed, so the
    // abort fires on the TIMEOUT_CYCLES-th ISSUE cycle.
    assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
    assign first_issue = (tmo_cnt_q == '0);
    assign issue_end   = (state_q == S_ISSUE) && (sb_done_i || tmo_hit);
    assign emit_hs     = (state_q == S_EMIT) && out_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (frag_valid_i) state_d = S_ISSUE;
            S_ISSUE: if (sb_done_i || tmo_hit) state_d = S_EMIT;
            S_EMIT:  if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; ready is qualified by reset so it reads 0 while held in reset
    always_comb begin
        frag_ready_o  = 1'b0;
        sb_start_o    = 1'b0;
        sb_flush_o    = 1'b0;
        out_valid_o   = 1'b0;
        out_pass_o    = 1'b0;
        out_timeout_o = 1'b0;
        busy_o        = 1'b0;
        unique case (state_q)
            S_IDLE:  frag_ready_o = rst_ni;
            S_ISSUE: begin
                sb_start_o = 1'b1;
                sb_flush_o = snap_flush_q;
                busy_o     = 1'b1;
            end
            S_EMIT: begin
                out_valid_o   = 1'b1;
                out_pass_o    = out_pass_q;
                out_timeout_o = out_timeout_q;
                busy_o        = 1'b1;
            end
            default: ;
        endcase
    end

    // Config, snapshot, timeout, result and counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_func_q    <= 3'b111;
            cfg_ref_q     <= '0;
            cfg_sfail_q   <= '0;
            cfg_dpfail_q  <= '0;
            cfg_dppass_q  <= '0;
            flush_pend_q  <= 1'b0;
            snap_x_q      <= '0;
            snap_y_q      <= '0;
            snap_dp_q     <= 1'b0;
            snap_func_q   <= '0;
            snap_ref_q    <= '0;
            snap_sfail_q  <= '0;
            snap_dpfail_q <= '0;
            snap_dppass_q <= '0;
            snap_flush_q  <= 1'b0;
            tmo_cnt_q     <= '0;
            pass_cap_q    <= 1'b0;
            out_pass_q    <= 1'b0;
            out_timeout_q <= 1'b0;
            pass_cnt_q    <= '0;
            fail_cnt_q    <= '0;
        end else begin
            if (cfg_we_i) begin
                cfg_func_q   <= cfg_func_i;
                cfg_ref_q    <= cfg_ref_i;
                cfg_sfail_q  <= cfg_sfail_i;
                cfg_dpfail_q <= cfg_dpfail_i;
                cfg_dppass_q <= cfg_dppass_i;
            end
            // A flush pulse coinciding with accept is kept for the next fragment
            flush_pend_q <= cfg_flush_i || (flush_pend_q && !accept);

            if (accept) begin
                snap_x_q      <= frag_x_i;
                snap_y_q      <= frag_y_i;
                snap_dp_q     <= frag_depth_pass_i;
                snap_func_q   <= cfg_func_q;
                snap_ref_q    <= cfg_ref_q;
                snap_sfail_q  <= cfg_sfail_q;
                snap_dpfail_q <= cfg_dpfail_q;
                snap_dppass_q <= cfg_dppass_q;
                snap_flush_q  <= flush_pend_q;
                tmo_cnt_q     <= '0;
            end else if (state_q == S_ISSUE) begin
                tmo_cnt_q <= tmo_cnt_q + TW'(1);
                if (first_issue) pass_cap_q <= sb_stencil_pass_i;
            end

            // Done on the first ISSUE cycle uses the live pass input since the
            // capture register has not been written yet.
            if (issue_end) begin
                out_timeout_q <= !sb_done_i;
                out_pass_q    <= sb_done_i && (first_issue ? sb_stencil_pass_i : pass_cap_q);
            end

            if (emit_hs) begin
                if (out_pass_q) pass_cnt_q <= pass_cnt_q + 16'd1;
                else            fail_cnt_q <= fail_cnt_q + 16'd1;
            end
        end
    end

    assign sb_pixel_x_o      = snap_x_q;
    assign sb_pixel_y_o      = snap_y_q;
    assign sb_frag_stencil_o = snap_ref_q;
    assign sb_stencil_func_o = snap_func_q;
    assign sb_sfail_o        = snap_sfail_q;
    assign sb_dpfail_o       = snap_dpfail_q;
    assign sb_dppass_o       = snap_dppass_q;
    assign sb_depth_pass_o   = snap_dp_q;
    assign out_x_o           = snap_x_q;
    assign out_y_o           = snap_y_q;
    assign pass_cnt_o        = pass_cnt_q;
    assign fail_cnt_o        = fail_cnt_q;

endmodule

// File: doc/stencil_test_sequencer.md
Name: stencil_test_sequencer

Overview:
- Initiator side of the stencil buffer test interface.
- Accepts rasterised fragments on a valid/ready stream and holds the CPU-programmed stencil state (func, ref, sfail/dpfail/dppass, flush request).
- For each fragment it drives one stencil test/update transaction (start held until done), captures the pass result, and forwards the fragment downstream tagged pass/fail/timeout.
- Sits between the rasteriser fragment output and the depth/colour stages.

Parameters:
X_RES, 1280, horizontal resolution; coordinate width is $clog2(X_RES)
Y_RES, 720, vertical resolution; coordinate width is $clog2(Y_RES)
STENCIL_SIZE, 8, stencil reference width
TIMEOUT_CYCLES, 15, maximum ISSUE cycles waiting for done before abort

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cfg_we_i  in  1  write all cfg_* fields into config registers
cfg_func_i  in  3  stencil function code, 000 NEVER .. 111 ALWAYS
cfg_ref_i  in  STENCIL_SIZE  stencil reference value
cfg_sfail_i / cfg_dpfail_i / cfg_dppass_i  in  3 each  stencil op codes, 000 KEEP .. 111 INVERT
cfg_flush_i  in  1  one-cycle pulse requesting a buffer flush
frag_valid_i  in  1  fragment valid
frag_ready_o  out  1  fragment accepted when valid&ready
frag_x_i / frag_y_i  in  $clog2(X_RES) / $clog2(Y_RES)  fragment coordinates
frag_depth_pass_i  in  1  depth result accompanying the fragment
sb_start_o  out  1  stencil transaction start/valid
sb_pixel_x_o / sb_pixel_y_o  out  coord widths  transaction coordinates
sb_frag_stencil_o  out  STENCIL_SIZE  reference value
sb_stencil_func_o / sb_sfail_o / sb_dpfail_o / sb_dppass_o  out  3 each  snapshot config
sb_depth_pass_o  out  1  snapshot depth result
sb_flush_o  out  1  flush request for this transaction
sb_stencil_pass_i  in  1  stencil test result from buffer
sb_done_i  in  1  transaction done pulse
out_valid_o  out  1  result valid
out_ready_i  in  1  downstream ready
out_x_o / out_y_o  out  coord widths  fragment coordinates
out_pass_o  out  1  captured stencil pass; 0 on timeout
out_timeout_o  out  1  transaction aborted by timeout
busy_o  out  1  FSM not in IDLE
pass_cnt_o / fail_cnt_o  out  16 each  wrapping counts of emitted pass / non-pass results

Behaviour:
- Reset (asynchronous): FSM to IDLE. All outputs 0, including frag_ready_o. All counters 0, flush_pending 0.
- Config reset values: func=ALWAYS(111), ref=0, all ops=KEEP.
- Config writes: when cfg_we_i=1, config registers update at the clock edge in any state.
- Snapshot: at fragment accept, x/y/depth_pass and all config are copied into snapshot registers. All sb_* outputs are driven only from the snapshot. Config writes during a transaction do not affect it.
- Flush: cfg_flush_i sets sticky flush_pending. At accept, flush_pending is copied to the snapshot flush bit, which drives sb_flush_o during ISSUE. flush_pending clears on accept, unless cfg_flush_i is high that same cycle, in which case it stays 1.
- State IDLE: frag_ready_o=1. On frag_valid_i, accept, clear the timeout counter, go to ISSUE.
- State ISSUE: sb_start_o=1 and held constant.
  - sb_stencil_pass_i is captured on the first ISSUE cycle only.
  - The timeout counter increments every ISSUE cycle.
  - sb_done_i=1: go to EMIT with timeout=0.
  - Counter reaches TIMEOUT_CYCLES with no done: go to EMIT with timeout=1 and pass forced to 0.
  - If done and timeout occur on the same cycle, done wins.
- State EMIT: sb_start_o=0, so the buffer sees at least one start-low cycle between transactions.
  - out_valid_o=1, with out_* stable until out_ready_i.
  - On handshake: increment pass_cnt_o if pass=1, else fail_cnt_o (timeouts count as fail). Both counters wrap 0xFFFF->0. Go to IDLE.
- Throughput: at most one fragment per transaction. frag_ready_o is 0 in ISSUE and EMIT.
- Minimum latency: accept to out_valid_o = (done latency) + 1 cycle.
- sb_done_i outside ISSUE is ignored.
- Reset mid-operation: immediate return to IDLE. sb_start_o drops and in-flight results are discarded.

Test Plan:
- Defaults after reset; frag (10,20), done on 4th ISSUE cycle, pass=1 -> sb_start_o high exactly 4 cycles; out_valid_o next cycle with x=10, y=20, pass=1; pass_cnt_o=1.
- cfg func=LESS, ref=5, sfail=ZERO written mid-ISSUE -> current transaction keeps ALWAYS/KEEP; next fragment drives func=001, ref=5, sfail=001.
- sb_done_i never asserted -> after 15 ISSUE cycles out_valid_o=1, out_timeout_o=1, out_pass_o=0; fail_cnt_o increments.
- cfg_flush_i pulse while busy -> sb_flush_o=1 only on the following transaction; pulse on the accept cycle is retained for the next one.
- out_ready_i low for 6 cycles in EMIT -> outputs stable, frag_ready_o=0, sb_start_o=0; fragment accepted the cycle after the handshake.
- rst_ni asserted during ISSUE -> same-cycle outputs 0, counters 0; done arriving after release is ignored.
